// File: rtl/issue_queue_age_select_pkg.sv
// Shared scheduler types for the issue-queue select path.
// Sizes here set the default geometry of every issue queue.
package SchedulerTypes;

    localparam int ISSUE_QUEUE_ENTRY_NUM   = 16;
    localparam int INT_ISSUE_WIDTH         = 2;
    localparam int DISPATCH_WIDTH          = 2;
    localparam int ISSUE_QUEUE_INDEX_WIDTH = $clog2(ISSUE_QUEUE_ENTRY_NUM);

    typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]   IssueQueueOneHotPath;

endpackage

// File: rtl/issue_queue_age_select_age_rank_count.sv
// Counts how many requesting entries are older than one entry.
// The count saturates at SEL_WIDTH because larger ranks never receive a grant.
module age_rank_count
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM = ISSUE_QUEUE_ENTRY_NUM,
    parameter int SEL_WIDTH = INT_ISSUE_WIDTH,
    localparam int CNT_W    = $clog2(SEL_WIDTH + 1)
) (
    input  logic [ENTRY_NUM-1:0] vec,
    output logic [CNT_W-1:0]     cnt
);

    // saturating popcount of the masked request vector
    always_comb begin
        cnt = {CNT_W{1'b0}};
        for (int j = 0; j < ENTRY_NUM; j++) begin
            if (vec[j] && (cnt != CNT_W'(SEL_WIDTH))) begin
                cnt = cnt + CNT_W'(1);
            end else begin
                cnt = cnt;
            end
        end
    end

endmodule

// File: rtl/issue_queue_age_select_chk.sv
// Protocol checks for the dispatch side of the age-select stage.
// Dispatch may only reuse a valid entry when that entry is being flushed in the same cycle.
module issue_queue_age_select_chk
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM  = ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISP_WIDTH = DISPATCH_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 dispatch [DISP_WIDTH],
    input IssueQueueIndexPath   dispatchPtr [DISP_WIDTH],
    input logic [ENTRY_NUM-1:0] validR,
    input logic [ENTRY_NUM-1:0] flushNowS
);

    for (genvar s = 0; s < DISP_WIDTH; s++) begin : gSlot
        assert property (@(posedge clk) disable iff (!rst)
            dispatch[s] |-> (!validR[dispatchPtr[s]] || flushNowS[dispatchPtr[s]]));
        for (genvar t = s + 1; t < DISP_WIDTH; t++) begin : gPair
            assert property (@(posedge clk) disable iff (!rst)
                (dispatch[s] && dispatch[t]) |-> (dispatchPtr[s] != dispatchPtr[t]));
        end
    end

endmodule

// File: rtl/issue_queue_age_select.sv
// Oldest-first select stage: age matrix written at dispatch, up to SEL_WIDTH
// registered grants per cycle; granted and flushed entries leave the queue.
module issue_queue_age_select
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM  = ISSUE_QUEUE_ENTRY_NUM,
    parameter int SEL_WIDTH  = INT_ISSUE_WIDTH,
    parameter int DISP_WIDTH = DISPATCH_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           dispatch [DISP_WIDTH],
    input  IssueQueueIndexPath             dispatchPtr [DISP_WIDTH],
    input  IssueQueueOneHotPath            opReady,
    input  logic                           flush,
    input  IssueQueueOneHotPath            flushMask,
    output logic                           selValid [SEL_WIDTH],
    output IssueQueueIndexPath             selPtr [SEL_WIDTH],
    output IssueQueueOneHotPath            selOneHot,
    output logic [$clog2(ENTRY_NUM+1)-1:0] freeCount
);

    localparam int CNT_W  = $clog2(SEL_WIDTH + 1);
    localparam int FREE_W = $clog2(ENTRY_NUM + 1);

    // olderR[i][j] set means entry j is older than entry i
    logic [ENTRY_NUM-1:0] validR;
    logic [ENTRY_NUM-1:0] olderR [ENTRY_NUM];

    logic [ENTRY_NUM-1:0] flushNowS;
    logic [ENTRY_NUM-1:0] reqS;
    logic [ENTRY_NUM-1:0] grantS;
    logic [CNT_W-1:0]     cntS [ENTRY_NUM];

    logic [ENTRY_NUM-1:0] validNextS;
    logic [ENTRY_NUM-1:0] olderNextS [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] rowS;
    logic [FREE_W-1:0]    freeNextS;
    logic                 selValidNextS [SEL_WIDTH];
    IssueQueueIndexPath   selPtrNextS [SEL_WIDTH];

    // request vector: flush masks an entry before it can be granted
    always_comb begin
        flushNowS = flush ? flushMask : {ENTRY_NUM{1'b0}};
        if (stall) begin
            reqS = {ENTRY_NUM{1'b0}};
        end else begin
            reqS = validR & opReady & ~flushNowS;
        end
    end

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : gRank
        age_rank_count #(
            .ENTRY_NUM (ENTRY_NUM),
            .SEL_WIDTH (SEL_WIDTH)
        ) uRank (
            .vec (reqS & olderR[i]),
            .cnt (cntS[i])
        );
    end

    // grant each entry into the slot equal to its age rank
    always_comb begin
        grantS = {ENTRY_NUM{1'b0}};
        for (int s = 0; s < SEL_WIDTH; s++) begin
            selValidNextS[s] = 1'b0;
            selPtrNextS[s]   = {ISSUE_QUEUE_INDEX_WIDTH{1'b0}};
        end
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (reqS[i] && (cntS[i] < CNT_W'(SEL_WIDTH))) begin
                grantS[i] = 1'b1;
            end else begin
                grantS[i] = 1'b0;
            end
            for (int s = 0; s < SEL_WIDTH; s++) begin
                if (grantS[i] && (cntS[i] == CNT_W'(s))) begin
                    selValidNextS[s] = 1'b1;
                    selPtrNextS[s]   = IssueQueueIndexPath'(i);
                end else begin
                    selValidNextS[s] = selValidNextS[s];
                end
            end
        end
    end

    // next validity and age matrix; later dispatch slots are younger than earlier ones
    always_comb begin
        validNextS = validR & ~grantS & ~flushNowS;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            olderNextS[i] = olderR[i];
        end
        for (int s = 0; s < DISP_WIDTH; s++) begin
            rowS = validR & ~grantS & ~flushNowS;
            for (int t = 0; t < s; t++) begin
                if (dispatch[t]) begin
                    rowS[dispatchPtr[t]] = 1'b1;
                end else begin
                    rowS = rowS;
                end
            end
            if (dispatch[s]) begin
                validNextS[dispatchPtr[s]] = 1'b1;
                olderNextS[dispatchPtr[s]] = rowS;
                for (int j = 0; j < ENTRY_NUM; j++) begin
                    olderNextS[j][dispatchPtr[s]] = 1'b0;
                end
            end else begin
                validNextS = validNextS;
            end
        end
    end

    // free entries after this cycle's dispatch, grant and flush
    always_comb begin
        freeNextS = {FREE_W{1'b0}};
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!validNextS[i]) begin
                freeNextS = freeNextS + FREE_W'(1);
            end else begin
                freeNextS = freeNextS;
            end
        end
    end

    // state update; grant outputs freeze while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            validR    <= {ENTRY_NUM{1'b0}};
            selOneHot <= {ENTRY_NUM{1'b0}};
            freeCount <= FREE_W'(ENTRY_NUM);
            for (int i = 0; i < ENTRY_NUM; i++) begin
                olderR[i] <= {ENTRY_NUM{1'b0}};
            end
            for (int s = 0; s < SEL_WIDTH; s++) begin
                selValid[s] <= 1'b0;
                selPtr[s]   <= {ISSUE_QUEUE_INDEX_WIDTH{1'b0}};
            end
        end else begin
            validR    <= validNextS;
            freeCount <= freeNextS;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                olderR[i] <= olderNextS[i];
            end
            if (!stall) begin
                selOneHot <= grantS;
                for (int s = 0; s < SEL_WIDTH; s++) begin
                    selValid[s] <= selValidNextS[s];
                    selPtr[s]   <= selPtrNextS[s];
                end
            end else begin
                selOneHot <= selOneHot;
            end
        end
    end

    issue_queue_age_select_chk #(
        .ENTRY_NUM  (ENTRY_NUM),
        .DISP_WIDTH (DISP_WIDTH)
    ) uChk (
        .clk         (clk),
        .rst         (rst),
        .dispatch    (dispatch),
        .dispatchPtr (dispatchPtr),
        .validR      (validR),
        .flushNowS   (flushNowS)
    );

endmodule
